// File: rtl/rv32i_types.sv
// Shared RV32I pipeline types: branch predictor entry layout, counter
// constants and the prediction word carried through the IF/ID/EX registers.
package rv32i_types;

    localparam int BRP_TAG_W     = 8;
    localparam int BRP_CTR_W     = 2;
    localparam int BRP_GHR_W_MAX = 16;

    // Canonical entry layout for the default predictor configuration.
    typedef struct packed {
        logic                 valid;
        logic [BRP_TAG_W-1:0] tag;
        logic [31:0]          target;
        logic [BRP_CTR_W-1:0] ctr;
        logic                 is_cond;
    } brp_entry_t;

    typedef struct packed {
        logic                     pred_taken;
        logic [31:0]              pred_target;
        logic [BRP_GHR_W_MAX-1:0] pred_ghr;
    } brp_pred_word_t;

    function automatic logic [31:0] brp_ctr_weak_taken(input int w);
        return 32'd1 << (w - 1);
    endfunction

    function automatic logic [31:0] brp_ctr_weak_not_taken(input int w);
        return (32'd1 << (w - 1)) - 32'd1;
    endfunction

endpackage

// File: rtl/brp_btb_bimodal_sat_counter.sv
// Saturating up/down counter, combinational next value only; the owner
// holds the state.
module sat_counter #(
    parameter int CTR_W = 2
) (
    input  logic [CTR_W-1:0] ctr,
    input  logic             up,
    output logic [CTR_W-1:0] ctr_next
);

    localparam logic [CTR_W-1:0] ONE = CTR_W'(1);
    localparam logic [CTR_W-1:0] TOP = {CTR_W{1'b1}};

    always_comb begin
        ctr_next = ctr;
        if (up) begin
            if (ctr != TOP) begin
                ctr_next = ctr + ONE;
            end
        end else if (ctr != '0) begin
            ctr_next = ctr - ONE;
        end
    end

endmodule

// File: rtl/brp_btb_bimodal.sv
// Tagged BTB with per-entry saturating counters and optional gshare indexing.
// Lookup is combinational in IF; EX resolutions update the table on the edge.
module brp_btb_bimodal
    import rv32i_types::*;
#(
    parameter int  ENTRIES = 64,
    parameter int  TAG_W   = 8,
    parameter int  CTR_W   = 2,
    parameter int  GHR_W   = 0,
    localparam int IDX_W   = $clog2(ENTRIES),
    localparam int GHW     = (GHR_W > 0) ? GHR_W : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     lk_pc,
    input  logic            lk_advance,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [31:0]     pred_target,
    output logic [GHW-1:0]  pred_ghr,
    input  logic            upd_valid,
    input  logic [31:0]     upd_pc,
    input  logic            upd_is_cond,
    input  logic            upd_taken,
    input  logic [31:0]     upd_target,
    input  logic [GHW-1:0]  upd_ghr,
    input  logic            upd_mispredict,
    output logic [31:0]     mispredict_cnt
);

    localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(brp_ctr_weak_taken(CTR_W));
    localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(brp_ctr_weak_not_taken(CTR_W));

    // Same layout as brp_entry_t, resized to this instance's parameters.
    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        logic [CTR_W-1:0] ctr;
        logic             is_cond;
    } entry_t;

    entry_t           entries_q [ENTRIES];
    entry_t           entries_d [ENTRIES];
    logic [CTR_W-1:0] ctr_next  [ENTRIES];
    logic [31:0]      mcnt_q, mcnt_d;
    logic [GHW-1:0]   ghr_q;

    logic [IDX_W-1:0] lk_hist, upd_hist;
    logic [IDX_W-1:0] lk_idx, upd_idx;
    logic [TAG_W-1:0] lk_tag, upd_tag;
    entry_t           lk_ent, upd_ent;
    logic             upd_hit;
    logic             unused_ok;

    generate
        if (GHR_W == 0) begin : g_bimodal
            assign ghr_q    = '0;
            assign lk_hist  = '0;
            assign upd_hist = '0;
        end else begin : g_gshare
            logic [GHW-1:0] ghr_d;

            // Cast zero-extends short histories and truncates long ones.
            assign lk_hist  = IDX_W'(ghr_q);
            assign upd_hist = IDX_W'(upd_ghr);

            always_comb begin
                ghr_d = ghr_q;
                if (upd_valid && upd_mispredict) begin
                    ghr_d = GHW'({upd_ghr, upd_taken});
                end else if (lk_advance && pred_hit && lk_ent.is_cond) begin
                    ghr_d = GHW'({ghr_q, pred_taken});
                end
            end

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    ghr_q <= '0;
                end else begin
                    ghr_q <= ghr_d;
                end
            end
        end
    endgenerate

    assign lk_idx  = lk_pc[IDX_W+1:2] ^ lk_hist;
    assign lk_tag  = lk_pc[TAG_W+IDX_W+1:IDX_W+2];
    assign upd_idx = upd_pc[IDX_W+1:2] ^ upd_hist;
    assign upd_tag = upd_pc[TAG_W+IDX_W+1:IDX_W+2];

    assign lk_ent  = entries_q[lk_idx];
    assign upd_ent = entries_q[upd_idx];
    assign upd_hit = upd_ent.valid && (upd_ent.tag == upd_tag);

    // Lookup sees only registered contents, so a same-cycle update is not bypassed.
    assign pred_hit    = lk_ent.valid && (lk_ent.tag == lk_tag);
    assign pred_taken  = pred_hit && (!lk_ent.is_cond || lk_ent.ctr[CTR_W-1]);
    assign pred_target = pred_taken ? lk_ent.target : (lk_pc + 32'd4);
    assign pred_ghr    = ghr_q;

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_ctr
            sat_counter #(.CTR_W(CTR_W)) u_ctr (
                .ctr      (entries_q[gi].ctr),
                .up       (upd_taken),
                .ctr_next (ctr_next[gi])
            );
        end
    endgenerate

    always_comb begin
        entries_d = entries_q;
        if (upd_valid) begin
            if (upd_hit) begin
                if (upd_is_cond) begin
                    entries_d[upd_idx].ctr = ctr_next[upd_idx];
                    if (upd_taken) begin
                        entries_d[upd_idx].target = upd_target;
                    end
                end else begin
                    entries_d[upd_idx].target = upd_target;
                end
            end else if (upd_taken) begin
                entries_d[upd_idx] = '{valid: 1'b1, tag: upd_tag, target: upd_target,
                                       ctr: CTR_WT, is_cond: upd_is_cond};
            end
        end
    end

    always_comb begin
        mcnt_d = mcnt_q;
        if (upd_valid && upd_mispredict && (mcnt_q != 32'hFFFF_FFFF)) begin
            mcnt_d = mcnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0,
                                  ctr: CTR_WNT, is_cond: 1'b0};
            end
            mcnt_q <= '0;
        end else begin
            entries_q <= entries_d;
            mcnt_q    <= mcnt_d;
        end
    end

    assign mispredict_cnt = mcnt_q;

    // Address bits outside index/tag and unread entry fields are intentionally dropped.
    assign unused_ok = ^{upd_pc, upd_ghr, lk_advance, lk_ent, upd_ent};

endmodule

// File: tb/tb_brp_btb_bimodal.sv
// Directed bench: a bimodal instance and a 4-bit gshare instance, one task
// per scenario with inline expected-value checks.
module tb_brp_btb_bimodal;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;
    int b_exp_cnt = 0;
    int g_exp_cnt = 0;

    logic        b_rst = 1'b1, b_lk_adv = 1'b0;
    logic [31:0] b_lk_pc = '0, b_tgt, b_cnt;
    logic        b_hit, b_taken;
    logic [0:0]  b_ghr;
    logic        b_upd_valid = 1'b0, b_upd_cond = 1'b0, b_upd_taken = 1'b0, b_upd_misp = 1'b0;
    logic [31:0] b_upd_pc = '0, b_upd_tgt = '0;
    logic [0:0]  b_upd_ghr = '0;

    logic        g_rst = 1'b1, g_lk_adv = 1'b0;
    logic [31:0] g_lk_pc = '0, g_tgt, g_cnt;
    logic        g_hit, g_taken;
    logic [3:0]  g_ghr;
    logic        g_upd_valid = 1'b0, g_upd_cond = 1'b0, g_upd_taken = 1'b0, g_upd_misp = 1'b0;
    logic [31:0] g_upd_pc = '0, g_upd_tgt = '0;
    logic [3:0]  g_upd_ghr = '0;

    brp_btb_bimodal #(.ENTRIES(64), .TAG_W(8), .CTR_W(2), .GHR_W(0)) u_bim (
        .clk(clk), .rst(b_rst), .lk_pc(b_lk_pc), .lk_advance(b_lk_adv),
        .pred_hit(b_hit), .pred_taken(b_taken), .pred_target(b_tgt), .pred_ghr(b_ghr),
        .upd_valid(b_upd_valid), .upd_pc(b_upd_pc), .upd_is_cond(b_upd_cond),
        .upd_taken(b_upd_taken), .upd_target(b_upd_tgt), .upd_ghr(b_upd_ghr),
        .upd_mispredict(b_upd_misp), .mispredict_cnt(b_cnt)
    );

    brp_btb_bimodal #(.ENTRIES(64), .TAG_W(8), .CTR_W(2), .GHR_W(4)) u_gsh (
        .clk(clk), .rst(g_rst), .lk_pc(g_lk_pc), .lk_advance(g_lk_adv),
        .pred_hit(g_hit), .pred_taken(g_taken), .pred_target(g_tgt), .pred_ghr(g_ghr),
        .upd_valid(g_upd_valid), .upd_pc(g_upd_pc), .upd_is_cond(g_upd_cond),
        .upd_taken(g_upd_taken), .upd_target(g_upd_tgt), .upd_ghr(g_upd_ghr),
        .upd_mispredict(g_upd_misp), .mispredict_cnt(g_cnt)
    );

    task automatic b_upd(input logic [31:0] pc, input logic cond, input logic tk,
                         input logic [31:0] tgt, input logic misp);
        b_upd_pc = pc; b_upd_cond = cond; b_upd_taken = tk; b_upd_tgt = tgt;
        b_upd_misp = misp; b_upd_valid = 1'b1;
        if (misp) b_exp_cnt++;
        @(posedge clk); #1;
        b_upd_valid = 1'b0; b_upd_misp = 1'b0;
        $display("bim upd pc=%h cond=%0b taken=%0b tgt=%h misp=%0b", pc, cond, tk, tgt, misp);
    endtask

    task automatic g_upd(input logic [31:0] pc, input logic cond, input logic tk,
                         input logic [31:0] tgt, input logic [3:0] ghr, input logic misp);
        g_upd_pc = pc; g_upd_cond = cond; g_upd_taken = tk; g_upd_tgt = tgt;
        g_upd_ghr = ghr; g_upd_misp = misp; g_upd_valid = 1'b1;
        if (misp) g_exp_cnt++;
        @(posedge clk); #1;
        g_upd_valid = 1'b0; g_upd_misp = 1'b0;
        $display("gsh upd pc=%h taken=%0b ghr=%b misp=%0b", pc, tk, ghr, misp);
    endtask

    task automatic test_reset;
        #2; b_rst = 1'b0; g_rst = 1'b0;
        b_lk_pc = 32'h60; g_lk_pc = 32'h60;
        #1;
        checks++; if (b_hit !== 1'b0) begin fails++; $display("FAIL rst_hit: got %0b want 0", b_hit); end
        checks++; if (b_taken !== 1'b0) begin fails++; $display("FAIL rst_taken: got %0b want 0", b_taken); end
        checks++; if (b_tgt !== 32'h64) begin fails++; $display("FAIL rst_tgt: got %h want 00000064", b_tgt); end
        checks++; if (g_ghr !== 4'b0000) begin fails++; $display("FAIL rst_gghr: got %b want 0000", g_ghr); end
        @(negedge clk); b_rst = 1'b1; g_rst = 1'b1;
        @(posedge clk); #1;
        checks++; if (b_hit !== 1'b0) begin fails++; $display("FAIL post_rst_hit: got %0b want 0", b_hit); end
        checks++; if (b_tgt !== 32'h64) begin fails++; $display("FAIL post_rst_tgt: got %h want 00000064", b_tgt); end
        checks++; if (b_cnt !== 32'd0) begin fails++; $display("FAIL post_rst_cnt: got %0d want 0", b_cnt); end
        checks++; if (b_ghr !== 1'b0) begin fails++; $display("FAIL post_rst_bghr: got %b want 0", b_ghr); end
        $display("reset: lookup 0x60 hit=%0b target=%h", b_hit, b_tgt);
    endtask

    task automatic test_allocate;
        b_upd(32'h100, 1'b1, 1'b1, 32'h80, 1'b0);
        b_lk_pc = 32'h100; #1;
        checks++; if (b_hit !== 1'b1) begin fails++; $display("FAIL alloc_hit: got %0b want 1", b_hit); end
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL alloc_taken: got %0b want 1", b_taken); end
        checks++; if (b_tgt !== 32'h80) begin fails++; $display("FAIL alloc_tgt: got %h want 00000080", b_tgt); end
    endtask

    task automatic test_hysteresis;
        b_upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b1);   // 10 -> 01
        b_lk_pc = 32'h100; #1;
        checks++; if (b_taken !== 1'b0) begin fails++; $display("FAIL hyst_01_taken: got %0b want 0", b_taken); end
        checks++; if (b_hit !== 1'b1) begin fails++; $display("FAIL hyst_01_hit: got %0b want 1", b_hit); end
        checks++; if (b_tgt !== 32'h104) begin fails++; $display("FAIL hyst_01_tgt: got %h want 00000104", b_tgt); end
        b_upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);   // 01 -> 00
        b_upd(32'h100, 1'b1, 1'b0, 32'h80, 1'b0);   // 00 stays
        b_upd(32'h100, 1'b1, 1'b1, 32'h88, 1'b1);   // 00 -> 01
        #1;
        checks++; if (b_taken !== 1'b0) begin fails++; $display("FAIL hyst_floor_taken: got %0b want 0", b_taken); end
        b_upd(32'h100, 1'b1, 1'b1, 32'h88, 1'b1);   // 01 -> 10
        #1;
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL hyst_10_taken: got %0b want 1", b_taken); end
        checks++; if (b_tgt !== 32'h88) begin fails++; $display("FAIL hyst_10_tgt: got %h want 00000088", b_tgt); end
        b_upd(32'h100, 1'b1, 1'b1, 32'h88, 1'b0);   // 10 -> 11
        b_upd(32'h100, 1'b1, 1'b1, 32'h88, 1'b0);   // 11 stays
        b_upd(32'h100, 1'b1, 1'b0, 32'h88, 1'b1);   // 11 -> 10
        #1;
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL hyst_ceiling_taken: got %0b want 1", b_taken); end
        b_upd(32'h100, 1'b1, 1'b0, 32'h88, 1'b1);   // 10 -> 01
        #1;
        checks++; if (b_taken !== 1'b0) begin fails++; $display("FAIL hyst_back_01_taken: got %0b want 0", b_taken); end
        checks++; if (b_cnt !== 32'(b_exp_cnt)) begin fails++; $display("FAIL hyst_cnt: got %0d want %0d", b_cnt, b_exp_cnt); end
    endtask

    task automatic test_misp_ignored;
        b_upd_misp = 1'b1; b_upd_pc = 32'h100; b_upd_taken = 1'b1;
        @(posedge clk); #1;
        b_upd_misp = 1'b0;
        $display("bim misp without valid");
        checks++; if (b_cnt !== 32'(b_exp_cnt)) begin fails++; $display("FAIL misp_novalid_cnt: got %0d want %0d", b_cnt, b_exp_cnt); end
        checks++; if (b_taken !== 1'b0) begin fails++; $display("FAIL misp_novalid_taken: got %0b want 0", b_taken); end
    endtask

    task automatic test_alias;
        b_lk_pc = 32'h200; #1;
        checks++; if (b_hit !== 1'b0) begin fails++; $display("FAIL alias_miss: got %0b want 0", b_hit); end
        checks++; if (b_tgt !== 32'h204) begin fails++; $display("FAIL alias_miss_tgt: got %h want 00000204", b_tgt); end
        b_upd(32'h500, 1'b1, 1'b0, 32'h700, 1'b0);  // miss, not taken: no allocation
        b_lk_pc = 32'h100; #1;
        checks++; if (b_hit !== 1'b1) begin fails++; $display("FAIL miss_nt_keeps: got %0b want 1", b_hit); end
        b_upd(32'h200, 1'b1, 1'b1, 32'h300, 1'b1);
        b_lk_pc = 32'h200; #1;
        checks++; if (b_hit !== 1'b1) begin fails++; $display("FAIL alias_repl_hit: got %0b want 1", b_hit); end
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL alias_repl_taken: got %0b want 1", b_taken); end
        checks++; if (b_tgt !== 32'h300) begin fails++; $display("FAIL alias_repl_tgt: got %h want 00000300", b_tgt); end
        b_lk_pc = 32'h100; #1;
        checks++; if (b_hit !== 1'b0) begin fails++; $display("FAIL alias_evicted: got %0b want 0", b_hit); end
    endtask

    task automatic test_jal;
        b_lk_pc = 32'h40;
        b_upd_pc = 32'h40; b_upd_cond = 1'b0; b_upd_taken = 1'b1; b_upd_tgt = 32'h400;
        b_upd_valid = 1'b1;
        #1;
        checks++; if (b_hit !== 1'b0) begin fails++; $display("FAIL jal_same_cycle: got %0b want 0", b_hit); end
        @(posedge clk); #1;
        b_upd_valid = 1'b0;
        $display("bim upd jal pc=00000040 tgt=00000400");
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL jal_taken: got %0b want 1", b_taken); end
        checks++; if (b_tgt !== 32'h400) begin fails++; $display("FAIL jal_tgt: got %h want 00000400", b_tgt); end
        b_upd(32'h40, 1'b0, 1'b1, 32'h440, 1'b1);
        #1;
        checks++; if (b_tgt !== 32'h440) begin fails++; $display("FAIL jal_retarget: got %h want 00000440", b_tgt); end
    endtask

    task automatic test_back_to_back;
        b_lk_pc = 32'h200;                          // entry at ctr 10
        b_upd_pc = 32'h200; b_upd_cond = 1'b1; b_upd_taken = 1'b0; b_upd_tgt = 32'h300;
        b_upd_valid = 1'b1;
        #1;
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL nobypass_pre: got %0b want 1", b_taken); end
        @(posedge clk); #1;                         // 10 -> 01
        checks++; if (b_taken !== 1'b0) begin fails++; $display("FAIL nobypass_post: got %0b want 0", b_taken); end
        b_upd_taken = 1'b1;
        @(posedge clk); #1;                         // 01 -> 10
        @(posedge clk); #1;                         // 10 -> 11
        b_upd_valid = 1'b0;
        $display("bim back-to-back taken updates at 00000200");
        b_upd(32'h200, 1'b1, 1'b0, 32'h300, 1'b0);  // 11 -> 10
        #1;
        checks++; if (b_taken !== 1'b1) begin fails++; $display("FAIL b2b_taken: got %0b want 1", b_taken); end
        checks++; if (b_cnt !== 32'(b_exp_cnt)) begin fails++; $display("FAIL b2b_cnt: got %0d want %0d", b_cnt, b_exp_cnt); end
        checks++; if (b_ghr !== 1'b0) begin fails++; $display("FAIL bim_ghr_tied: got %b want 0", b_ghr); end
    endtask

    task automatic test_gshare;
        g_upd(32'h100, 1'b1, 1'b1, 32'h80, 4'b0000, 1'b0);  // idx 0
        g_upd(32'h100, 1'b1, 1'b1, 32'h90, 4'b0001, 1'b0);  // idx 1
        g_lk_pc = 32'h100; g_lk_adv = 1'b1; #1;
        checks++; if (g_tgt !== 32'h80) begin fails++; $display("FAIL gsh_h0_tgt: got %h want 00000080", g_tgt); end
        checks++; if (g_ghr !== 4'b0000) begin fails++; $display("FAIL gsh_h0_ghr: got %b want 0000", g_ghr); end
        @(posedge clk); #1;
        g_lk_adv = 1'b0;
        checks++; if (g_ghr !== 4'b0001) begin fails++; $display("FAIL gsh_shift: got %b want 0001", g_ghr); end
        checks++; if (g_tgt !== 32'h90) begin fails++; $display("FAIL gsh_h1_tgt: got %h want 00000090", g_tgt); end
        g_lk_adv = 1'b1;                             // would shift to 0011
        g_upd(32'h100, 1'b1, 1'b0, 32'h80, 4'b0000, 1'b1);
        g_lk_adv = 1'b0;
        checks++; if (g_ghr !== 4'b0000) begin fails++; $display("FAIL gsh_recover: got %b want 0000", g_ghr); end
        checks++; if (g_cnt !== 32'(g_exp_cnt)) begin fails++; $display("FAIL gsh_cnt1: got %0d want %0d", g_cnt, g_exp_cnt); end
        checks++; if (g_taken !== 1'b0) begin fails++; $display("FAIL gsh_h0_weak: got %0b want 0", g_taken); end
        checks++; if (g_tgt !== 32'h104) begin fails++; $display("FAIL gsh_h0_weak_tgt: got %h want 00000104", g_tgt); end
        g_upd(32'h100, 1'b1, 1'b1, 32'h80, 4'b0000, 1'b1);
        checks++; if (g_ghr !== 4'b0001) begin fails++; $display("FAIL gsh_recover_tk: got %b want 0001", g_ghr); end
        g_lk_adv = 1'b1;
        @(posedge clk); #1;
        g_lk_adv = 1'b0;
        $display("gsh advance on taken hit, ghr=%b", g_ghr);
        checks++; if (g_ghr !== 4'b0011) begin fails++; $display("FAIL gsh_shift2: got %b want 0011", g_ghr); end
        checks++; if (g_hit !== 1'b0) begin fails++; $display("FAIL gsh_idx3_miss: got %0b want 0", g_hit); end
    endtask

    task automatic test_async_reset;
        g_lk_pc = 32'h10C; #1;                       // idx 3 ^ 0011 = 0, tag 1
        checks++; if (g_hit !== 1'b1) begin fails++; $display("FAIL arst_pre_hit: got %0b want 1", g_hit); end
        g_upd_pc = 32'h300; g_upd_cond = 1'b1; g_upd_taken = 1'b1; g_upd_tgt = 32'h500;
        g_upd_ghr = 4'b0000; g_upd_valid = 1'b1;
        g_rst = 1'b0; g_exp_cnt = 0;
        #1;
        checks++; if (g_hit !== 1'b0) begin fails++; $display("FAIL arst_hit: got %0b want 0", g_hit); end
        checks++; if (g_ghr !== 4'b0000) begin fails++; $display("FAIL arst_ghr: got %b want 0000", g_ghr); end
        checks++; if (g_cnt !== 32'd0) begin fails++; $display("FAIL arst_cnt: got %0d want 0", g_cnt); end
        checks++; if (g_tgt !== 32'h110) begin fails++; $display("FAIL arst_tgt: got %h want 00000110", g_tgt); end
        @(posedge clk); #1;
        g_upd_valid = 1'b0;
        @(negedge clk); g_rst = 1'b1;
        @(posedge clk); #1;
        $display("gsh async reset with pending update, released");
        g_lk_pc = 32'h300; #1;
        checks++; if (g_hit !== 1'b0) begin fails++; $display("FAIL arst_discard: got %0b want 0", g_hit); end
        g_lk_pc = 32'h100; #1;
        checks++; if (g_hit !== 1'b0) begin fails++; $display("FAIL arst_cleared: got %0b want 0", g_hit); end
    endtask

    initial begin
        test_reset();
        test_allocate();
        test_hysteresis();
        test_misp_ignored();
        test_alias();
        test_jal();
        test_back_to_back();
        test_gshare();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
